ysyx_25040118_dmem_ctrl: RTL

Multi-cycle data-memory controller that sits directly downstream of the load/store unit. It accepts one load/store request at a time over a valid/ready handshake, translates the virtual address to a physical address, and aligns byte lanes. It runs a single transaction on a word-wide memory bus, then returns the sign- or zero-extended load data (or a store acknowledgement) to the LSU. The LSU stalls the core while `req_ready` or `rsp_valid` is pending.

---
 rtl/ysyx_25040118_dmem_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040118_dmem_ctrl.sv
// ysyx_25040118_dmem_ctrl
// Data-memory controller between the LSU and a word-wide memory bus.
// It takes one load/store at a time, maps the virtual address onto the
// physical bus window, and drives one bus transaction. Sub-word stores are
// lane-replicated with byte strobes, and load data is shifted and extended.
// Misaligned or illegal requests are answered with rsp_err and cause no bus
// traffic.
// Optional build macro DMEM_TIMEOUT_EN enables use of TIMEOUT_CYCLES.
// It bounds the wait for a bus response and reports a timeout as an error.
module ysyx_25040118_dmem_ctrl #(
  parameter logic [31:0] MEM_BASE       = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] phys_q, phys_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef DMEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic        req_legal;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  // Decide whether the incoming request is a supported, naturally aligned access.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000:         req_legal = 1'b1;
      3'b001:         req_legal = ~req_addr[0];
      3'b010:         req_legal = (req_addr[1:0] == 2'b00);
      3'b100, 3'b101: req_legal = ~req_we & (~req_funct3[0] | ~req_addr[0]);
      default:        req_legal = 1'b0;
    endcase
  end

  // Put store data on every lane that the access size allows, and enable only the addressed bytes.
  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = 32'h0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_strb  = 4'b0001 << req_addr[1:0];
          st_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_strb  = 4'b0011 << req_addr[1:0];
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          st_strb  = 4'b1111;
          st_wdata = req_wdata;
        end
      endcase
    end
  end

  // Move the addressed byte or halfword down to bit 0, then extend it as the load type requires.
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    ld_data  = 32'h0;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_data = ld_shift;
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

  // Compute the next state and the request/response registers; by default every register holds.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    phys_d   = phys_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          phys_d   = req_addr - MEM_BASE;
          wdata_d  = st_wdata;
          wstrb_d  = st_strb;
          if (req_legal) begin
            state_d = S_REQ;
          end else begin
            state_d = S_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_WAIT;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          err_d   = mem_rerr;
          rdata_d = (mem_rerr || we_q) ? 32'h0 : ld_data;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; a reset clears them and drops any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      phys_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      phys_q   <= phys_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Outputs come from registered state only and are zero outside the phase that owns them.
  assign req_ready = rst & (state_q == S_IDLE);
  assign mem_valid = (state_q == S_REQ);
  assign mem_addr  = mem_valid ? (phys_q & 32'hFFFF_FFFC) : 32'h0;
  assign mem_we    = mem_valid & we_q;
  assign mem_wdata = mem_valid ? wdata_q : 32'h0;
  assign mem_wstrb = mem_valid ? wstrb_q : 4'b0000;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

endmodule
